// File: rtl/fullmatch_page_memory.sv
// Two-page FullMatch storage: MatchCalculator write side, registered read side for the
// downstream consumer, per-page nentries registers and a sticky cross-check of the
// reported nentries against the number of data writes actually seen on each page.
// Optional build macro FM_PAGE_MEM_OUTREG_EN adds a second dout register (read latency 2).
module fullmatch_page_memory #(
  parameter int unsigned DataWidth = 45,
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned NentWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wea_i,
  input  logic [AddrWidth-1:0] writeaddr_i,
  input  logic [DataWidth-1:0] din_i,
  input  logic                 nentries_0_we_i,
  input  logic [NentWidth-1:0] nentries_0_din_i,
  input  logic                 nentries_1_we_i,
  input  logic [NentWidth-1:0] nentries_1_din_i,
  input  logic                 clear_page_we_i,
  input  logic                 clear_page_i,
  input  logic                 enb_i,
  input  logic [AddrWidth-1:0] readaddr_i,
  output logic [DataWidth-1:0] dout_o,
  output logic [NentWidth-1:0] nentries_0_dout_o,
  output logic [NentWidth-1:0] nentries_1_dout_o,
  output logic                 count_err_o
);

  localparam int unsigned Depth = 2 ** AddrWidth;
  // Write counters saturate at one full page of entries.
  localparam logic [NentWidth-1:0] MaxCnt = NentWidth'(2 ** (AddrWidth - 1));

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rdata_q;

  logic [NentWidth-1:0] wcnt0_q, wcnt0_d, wcnt1_q, wcnt1_d;
  logic [NentWidth-1:0] nent0_q, nent0_d, nent1_q, nent1_d;
  logic [NentWidth-1:0] base0, base1;
  logic                 err_q, err_d;
  logic                 wr_page1;
  logic                 clr0, clr1;

  assign wr_page1 = writeaddr_i[AddrWidth-1];
  assign clr0     = clear_page_we_i && !clear_page_i;
  assign clr1     = clear_page_we_i && clear_page_i;

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wea_i) begin
      mem_q[writeaddr_i] <= din_i;
    end
  end

  // Read-first registered read port: a same-cycle write is not visible here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (enb_i) begin
      rdata_q <= mem_q[readaddr_i];
    end
  end

  // Counter/nentries next state: clear first, then this cycle's write, then the compare.
  always_comb begin
    base0 = clr0 ? '0 : wcnt0_q;
    base1 = clr1 ? '0 : wcnt1_q;

    wcnt0_d = base0;
    if (wea_i && !wr_page1 && (base0 != MaxCnt)) begin
      wcnt0_d = base0 + NentWidth'(1);
    end
    wcnt1_d = base1;
    if (wea_i && wr_page1 && (base1 != MaxCnt)) begin
      wcnt1_d = base1 + NentWidth'(1);
    end

    nent0_d = clr0 ? '0 : nent0_q;
    if (nentries_0_we_i) begin
      nent0_d = nentries_0_din_i;
    end
    nent1_d = clr1 ? '0 : nent1_q;
    if (nentries_1_we_i) begin
      nent1_d = nentries_1_din_i;
    end

    err_d = err_q;
    if (nentries_0_we_i && (nentries_0_din_i != wcnt0_d)) begin
      err_d = 1'b1;
    end
    if (nentries_1_we_i && (nentries_1_din_i != wcnt1_d)) begin
      err_d = 1'b1;
    end
  end

  // Per-page counters, nentries registers and the sticky error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wcnt0_q <= '0;
      wcnt1_q <= '0;
      nent0_q <= '0;
      nent1_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wcnt0_q <= wcnt0_d;
      wcnt1_q <= wcnt1_d;
      nent0_q <= nent0_d;
      nent1_q <= nent1_d;
      err_q   <= err_d;
    end
  end

  assign nentries_0_dout_o = nent0_q;
  assign nentries_1_dout_o = nent1_q;
  assign count_err_o       = err_q;

`ifdef FM_PAGE_MEM_OUTREG_EN
  logic                 en_q;
  logic [DataWidth-1:0] oreg_q;

  // Second output stage only advances behind a real first-stage read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q   <= 1'b0;
      oreg_q <= '0;
    end else begin
      en_q <= enb_i;
      if (en_q) begin
        oreg_q <= rdata_q;
      end
    end
  end

  assign dout_o = oreg_q;
`else
  assign dout_o = rdata_q;
`endif

endmodule
